// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-flop synchroniser, per-channel stability filter, edge strobes, long-press level.
// Latency: pin change captured at edge E0 appears on SIGNAL_OUT/RISE/FALL at edge E0+1+BOUNCE_FILTER; HELD HOLD_CYCLES edges after rise.
// Backpressure: none; inputs are free-running levels and every output is valid on every cycle.
module debounce_multi #(
    parameter int                  CHANNELS      = 4,
    parameter int                  BOUNCE_FILTER = 100000,
    parameter int                  HOLD_CYCLES   = 0,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic [CHANNELS-1:0] SIGNAL_IN,
    output logic [CHANNELS-1:0] SIGNAL_OUT,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL,
    output logic [CHANNELS-1:0] HELD,
    output logic                CHANGED
);

    // Sized to hold BOUNCE_FILTER itself so power-of-two filters never wrap.
    localparam int CW = $clog2(BOUNCE_FILTER + 1);

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] out_d;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] held_q;
    logic [CHANNELS-1:0] held_d;

    // Synchronisers, filtered level and strobes; strobes compare next vs current level so they
    // coincide with the first cycle the new level is visible. Reset never produces a strobe.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
            out_q   <= RESET_VALUE;
            rise_q  <= '0;
            fall_q  <= '0;
            held_q  <= '0;
        end else begin
            sync1_q <= SIGNAL_IN;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            rise_q  <= out_d & ~out_q;
            fall_q  <= ~out_d & out_q;
            held_q  <= held_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          ch_out_d;

        // Stability filter: any matching sample restarts the count, the BOUNCE_FILTER-th
        // consecutive mismatch accepts the new level.
        always_comb begin
            cnt_d    = cnt_q;
            ch_out_d = out_q[i];
            if (sync2_q[i] == out_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(BOUNCE_FILTER - 1)) begin
                ch_out_d = sync2_q[i];
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Filter counter register.
        always_ff @(posedge CLOCK) begin
            if (RESET) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign out_d[i] = ch_out_d;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam int HW = $clog2(HOLD_CYCLES + 1);
            logic [HW-1:0] hc_q;
            logic [HW-1:0] hc_d;

            // Long-press timer: cleared while low or on any level change, saturates at HOLD_CYCLES.
            // HELD is taken from the next count so it asserts exactly HOLD_CYCLES edges after the rise
            // and drops on the same edge the level falls.
            always_comb begin
                hc_d = hc_q;
                if (!out_q[i] || (ch_out_d != out_q[i])) begin
                    hc_d = '0;
                end else if (hc_q != HW'(HOLD_CYCLES)) begin
                    hc_d = hc_q + HW'(1);
                end
            end

            // Hold counter register.
            always_ff @(posedge CLOCK) begin
                if (RESET) begin
                    hc_q <= '0;
                end else begin
                    hc_q <= hc_d;
                end
            end

            assign held_d[i] = (hc_d == HW'(HOLD_CYCLES));
        end else begin : g_no_hold
            assign held_d[i] = 1'b0;
        end
    end

    assign SIGNAL_OUT = out_q;
    assign RISE       = rise_q;
    assign FALL       = fall_q;
    assign HELD       = held_q;
    assign CHANGED    = |(rise_q | fall_q);

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (CHANNELS=3, BOUNCE_FILTER=4, HOLD_CYCLES=10, RESET_VALUE=3'b100).
// Expected output vectors are queued with the edge at which they must appear when stimulus is driven.
// Observed vector layout: {SIGNAL_OUT, RISE, FALL, HELD, CHANGED}.
module tb_debounce_multi;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [2:0] SIGNAL_IN;
    logic [2:0] SIGNAL_OUT;
    logic [2:0] RISE;
    logic [2:0] FALL;
    logic [2:0] HELD;
    logic       CHANGED;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    typedef struct {
        int          edge_no;
        string       name;
        logic [12:0] exp;
    } sb_t;

    sb_t sb[$];

    wire [12:0] obs = {SIGNAL_OUT, RISE, FALL, HELD, CHANGED};

    debounce_multi #(
        .CHANNELS     (3),
        .BOUNCE_FILTER(4),
        .HOLD_CYCLES  (10),
        .RESET_VALUE  (3'b100)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .SIGNAL_IN (SIGNAL_IN),
        .SIGNAL_OUT(SIGNAL_OUT),
        .RISE      (RISE),
        .FALL      (FALL),
        .HELD      (HELD),
        .CHANGED   (CHANGED)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        edge_cnt++;
        #1;
    endtask

    task automatic push(input int e, input string n, input logic [2:0] o, input logic [2:0] r,
                        input logic [2:0] f, input logic [2:0] h, input logic c);
        sb_t t;
        t.edge_no = e;
        t.name    = n;
        t.exp     = {o, r, f, h, c};
        sb.push_back(t);
    endtask

    task automatic test_reset();
        sb_t e;
        int  n;
        RESET     = 1'b1;
        SIGNAL_IN = 3'b000;
        tick();
        tick();
        checks++;
        if (obs !== 13'b100_000_000_000_0) begin
            failures++;
            $display("FAIL reset_state got=%b want=%b", obs, 13'b100_000_000_000_0);
        end
        RESET = 1'b0;
        n = edge_cnt;
        push(n + 5, "rst_pre_fall", 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 6, "rst_fall",     3'b000, 3'b000, 3'b100, 3'b000, 1'b1);
        push(n + 7, "rst_fall_end", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL reset_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_rise();
        sb_t e;
        int  n;
        n = edge_cnt;
        SIGNAL_IN = 3'b001;
        push(n + 5, "rise_pre",  3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 6, "rise",      3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
        push(n + 7, "rise_end",  3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
            if (k == 7) begin
                SIGNAL_IN = 3'b000;
                push(edge_cnt + 5, "fall0_pre", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
                push(edge_cnt + 6, "fall0",     3'b000, 3'b000, 3'b001, 3'b000, 1'b1);
                push(edge_cnt + 7, "fall0_end", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            end
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL rise_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        sb_t e;
        int  n;
        // 3-high / 2-low pulse train, ten pulses, must never pass the filter.
        for (int k = 0; k < 56; k++) begin
            SIGNAL_IN = (k < 50 && (k % 5) < 3) ? 3'b001 : 3'b000;
            push(edge_cnt + 1, "glitch_quiet", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
        end
        // A pulse of exactly four clocks is accepted, then filtered back out.
        n = edge_cnt;
        SIGNAL_IN = 3'b001;
        push(n + 5,  "pulse4_pre",  3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 6,  "pulse4_rise", 3'b001, 3'b001, 3'b000, 3'b000, 1'b1);
        push(n + 7,  "pulse4_high", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 9,  "pulse4_hold", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 10, "pulse4_fall", 3'b000, 3'b000, 3'b001, 3'b000, 1'b1);
        push(n + 11, "pulse4_end",  3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
            if (k == 4) SIGNAL_IN = 3'b000;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL glitch_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_hold();
        sb_t e;
        int  n;
        n = edge_cnt;
        SIGNAL_IN = 3'b010;
        push(n + 6,  "hold_rise",   3'b010, 3'b010, 3'b000, 3'b000, 1'b1);
        push(n + 15, "hold_before", 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
        push(n + 16, "hold_assert", 3'b010, 3'b000, 3'b000, 3'b010, 1'b0);
        push(n + 20, "hold_sat",    3'b010, 3'b000, 3'b000, 3'b010, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
            if (k == 20) begin
                SIGNAL_IN = 3'b000;
                push(edge_cnt + 5, "hold_pre_rel", 3'b010, 3'b000, 3'b000, 3'b010, 1'b0);
                push(edge_cnt + 6, "hold_release", 3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
                push(edge_cnt + 7, "hold_rel_end", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            end
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL hold_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        int  n;
        n = edge_cnt;
        SIGNAL_IN = 3'b101;
        push(n + 6, "multi_rise", 3'b101, 3'b101, 3'b000, 3'b000, 1'b1);
        for (int k = 1; k <= 22; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
            if (k == 7) begin
                SIGNAL_IN = 3'b010;
                push(edge_cnt + 5, "toggle_pre", 3'b101, 3'b000, 3'b000, 3'b000, 1'b0);
                push(edge_cnt + 6, "toggle_all", 3'b010, 3'b010, 3'b101, 3'b000, 1'b1);
                push(edge_cnt + 7, "toggle_end", 3'b010, 3'b000, 3'b000, 3'b000, 1'b0);
            end
            if (k == 14) begin
                SIGNAL_IN = 3'b000;
                push(edge_cnt + 6, "multi_clear",     3'b000, 3'b000, 3'b010, 3'b000, 1'b1);
                push(edge_cnt + 7, "multi_clear_end", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            end
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL multi_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        sb_t e;
        int  n;
        n = edge_cnt;
        SIGNAL_IN = 3'b001;
        push(n + 5, "mid_cnt3", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
        for (int k = 1; k <= 22; k++) begin
            tick();
            while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (e.edge_no != edge_cnt || obs !== e.exp) begin
                    failures++;
                    $display("FAIL %s edge=%0d got=%b want=%b", e.name, edge_cnt, obs, e.exp);
                end
            end
            if (k == 5) begin
                // cnt on ch0 is 3 here; the next edge would have accepted without reset.
                RESET = 1'b1;
                push(edge_cnt + 1, "mid_reset", 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
            end
            if (k == 6) begin
                RESET = 1'b0;
                push(edge_cnt + 5, "mid_refill", 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
                push(edge_cnt + 6, "mid_accept", 3'b001, 3'b001, 3'b100, 3'b000, 1'b1);
                push(edge_cnt + 7, "mid_end",    3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
            end
            if (k == 13) begin
                SIGNAL_IN = 3'b000;
                push(edge_cnt + 6, "mid_fall",     3'b000, 3'b000, 3'b001, 3'b000, 1'b1);
                push(edge_cnt + 7, "mid_fall_end", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
            end
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL mid_pending got=%0d want=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        RESET     = 1'b1;
        SIGNAL_IN = 3'b000;
        test_reset();
        test_rise();
        test_glitch();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
